// File: rtl/core_dump_pkg.sv
// Shared state encoding, dump-source tags and width helper for core_state_dumper.
package core_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    REG_LOAD,
    REG_SEND,
    MEM_LOAD,
    MEM_WAIT,
    MEM_SEND,
    DONE
  } dump_state_e;

  localparam logic DUMP_SRC_REG = 1'b0;
  localparam logic DUMP_SRC_MEM = 1'b1;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_state_dumper.sv
// Runs the core for a bounded number of cycles (or until halt), then streams
// every register followed by every data-memory word over a valid/ready channel.
module core_state_dumper
  import core_dump_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned MEM_ADDR_W = 8,
  parameter int unsigned MAX_CYCLES = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic                                        halt,
  output logic                                        run_enable,
  output logic [REG_ADDR_W-1:0]                       reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]                       reg_rd_data,
  output logic [MEM_ADDR_W-1:0]                       mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]                       mem_rd_data,
  output logic                                        dump_valid,
  input  logic                                        dump_ready,
  output logic [DATA_WIDTH-1:0]                       dump_data,
  output logic                                        dump_src,
  output logic [max_w(REG_ADDR_W, MEM_ADDR_W)-1:0]    dump_addr,
  output logic [CNT_W-1:0]                            cycle_count,
  output logic                                        done
);

  localparam int unsigned IDX_W = max_w(REG_ADDR_W, MEM_ADDR_W);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  dump_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]        addr_q, addr_d;
  logic                    src_q, src_d;
  logic                    run_q, valid_q, done_q;
  logic                    handshake;

  assign handshake = valid_q && dump_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    data_d  = data_q;
    addr_d  = addr_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          count_d = '0;
        end
      end
      RUN: begin
        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        if (halt || count_q == CNT_LAST) state_d = REG_LOAD;
      end
      REG_LOAD: begin
        data_d  = reg_rd_data;
        addr_d  = idx_q;
        src_d   = DUMP_SRC_REG;
        state_d = REG_SEND;
      end
      REG_SEND: begin
        if (handshake) begin
          if (idx_q == REG_LAST) begin
            idx_d   = '0;
            state_d = MEM_LOAD;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = REG_LOAD;
          end
        end
      end
      MEM_LOAD: state_d = MEM_WAIT;
      MEM_WAIT: begin
        data_d  = mem_rd_data;
        addr_d  = idx_q;
        src_d   = DUMP_SRC_MEM;
        state_d = MEM_SEND;
      end
      MEM_SEND: begin
        if (handshake) begin
          if (idx_q == MEM_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = MEM_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      src_q   <= DUMP_SRC_REG;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      run_q   <= (state_d == RUN);
      valid_q <= (state_d == REG_SEND) || (state_d == MEM_SEND);
      done_q  <= (state_d == DONE);
    end
  end

  assign run_enable  = run_q;
  assign reg_rd_addr = idx_q[REG_ADDR_W-1:0];
  assign mem_rd_addr = idx_q[MEM_ADDR_W-1:0];
  assign dump_valid  = valid_q;
  assign dump_data   = data_q;
  assign dump_src    = src_q;
  assign dump_addr   = addr_q;
  assign cycle_count = count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_core_state_dumper.sv
// Scoreboard bench for core_state_dumper: default-size instance plus a small
// REG_COUNT=4 / MEM_DEPTH=5 instance.
module tb_core_state_dumper;

  logic clock;
  logic reset_n;

  logic [31:0] regs [32];
  logic [31:0] mem  [256];

  // Instance A: default parameters
  logic        start_a, halt_a, run_enable_a, dump_valid_a, dump_ready_a, dump_src_a, done_a;
  logic [4:0]  reg_rd_addr_a;
  logic [7:0]  mem_rd_addr_a, dump_addr_a;
  logic [31:0] reg_rd_data_a, mem_rd_data_a, dump_data_a;
  logic [15:0] cycle_count_a;

  // Instance B: small geometry
  logic        start_b, halt_b, run_enable_b, dump_valid_b, dump_ready_b, dump_src_b, done_b;
  logic [1:0]  reg_rd_addr_b;
  logic [2:0]  mem_rd_addr_b, dump_addr_b;
  logic [31:0] reg_rd_data_b, mem_rd_data_b, dump_data_b;
  logic [15:0] cycle_count_b;

  core_state_dumper #(
    .DATA_WIDTH(32), .REG_COUNT(32), .REG_ADDR_W(5), .MEM_DEPTH(256),
    .MEM_ADDR_W(8), .MAX_CYCLES(16), .CNT_W(16)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .halt(halt_a),
    .run_enable(run_enable_a), .reg_rd_addr(reg_rd_addr_a), .reg_rd_data(reg_rd_data_a),
    .mem_rd_addr(mem_rd_addr_a), .mem_rd_data(mem_rd_data_a), .dump_valid(dump_valid_a),
    .dump_ready(dump_ready_a), .dump_data(dump_data_a), .dump_src(dump_src_a),
    .dump_addr(dump_addr_a), .cycle_count(cycle_count_a), .done(done_a)
  );

  core_state_dumper #(
    .DATA_WIDTH(32), .REG_COUNT(4), .REG_ADDR_W(2), .MEM_DEPTH(5),
    .MEM_ADDR_W(3), .MAX_CYCLES(3), .CNT_W(16)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .halt(halt_b),
    .run_enable(run_enable_b), .reg_rd_addr(reg_rd_addr_b), .reg_rd_data(reg_rd_data_b),
    .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(mem_rd_data_b), .dump_valid(dump_valid_b),
    .dump_ready(dump_ready_b), .dump_data(dump_data_b), .dump_src(dump_src_b),
    .dump_addr(dump_addr_b), .cycle_count(cycle_count_b), .done(done_b)
  );

  // Core models: combinational register file, one-cycle synchronous memory
  assign reg_rd_data_a = regs[reg_rd_addr_a];
  assign reg_rd_data_b = regs[reg_rd_addr_b];
  always @(posedge clock) begin
    mem_rd_data_a <= mem[mem_rd_addr_a];
    mem_rd_data_b <= mem[mem_rd_addr_b];
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard queues: {src, addr(8), data(32)}
  logic [40:0] qa[$];
  logic [40:0] qb[$];
  int unsigned words_a = 0;
  int unsigned words_b = 0;
  bit          b_last_pending = 1'b0;

  initial forever begin
    @(negedge clock);
    if (b_last_pending) begin
      check("B done the cycle after last handshake", done_b, 1'b1);
      b_last_pending = 1'b0;
    end
    if (dump_valid_a) begin
      if (qa.size() == 0) check("A extra word", dump_valid_a, 1'b0);
      else begin
        check("A dump word", {dump_src_a, dump_addr_a, dump_data_a}, qa[0]);
        if (dump_ready_a) begin
          void'(qa.pop_front());
          words_a++;
        end
      end
    end
    if (dump_valid_b) begin
      if (qb.size() == 0) check("B extra word", dump_valid_b, 1'b0);
      else begin
        check("B dump word", {dump_src_b, 5'b0, dump_addr_b, dump_data_b}, qb[0]);
        if (dump_ready_b) begin
          void'(qb.pop_front());
          words_b++;
          if (qb.size() == 0) begin
            check("B done low at last handshake", done_b, 1'b0);
            b_last_pending = 1'b1;
          end
        end
      end
    end
  end

  // Run-cycle counter and halt driver for A
  int unsigned run_cnt_a = 0;
  int          halt_at   = -1;
  initial forever begin
    @(negedge clock);
    if (run_enable_a) begin
      halt_a = (halt_at >= 0 && run_cnt_a == int'(halt_at)) ? 1'b1 : 1'b0;
      run_cnt_a++;
    end else begin
      halt_a = 1'b0;
    end
  end

  // Back-pressure driver for A: seven stalled cycles on r8 and on mem[3]
  bit          stall_en = 1'b0;
  int unsigned stall_r  = 0;
  int unsigned stall_m  = 0;
  initial forever begin
    @(posedge clock);
    #1;
    dump_ready_a = 1'b1;
    if (stall_en && dump_valid_a) begin
      if (dump_src_a == 1'b0 && dump_addr_a == 8'd8 && stall_r < 7) begin
        dump_ready_a = 1'b0;
        stall_r++;
      end else if (dump_src_a == 1'b1 && dump_addr_a == 8'd3 && stall_m < 7) begin
        dump_ready_a = 1'b0;
        stall_m++;
      end
    end
  end

  task automatic push_full_a();
    for (int i = 0; i < 32; i++) qa.push_back({1'b0, 8'(i), regs[i]});
    for (int j = 0; j < 256; j++) qa.push_back({1'b1, 8'(j), mem[j]});
  endtask

  task automatic pulse_start_a();
    @(posedge clock);
    #1 start_a = 1'b1;
    @(posedge clock);
    #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int unsigned limit);
    int unsigned n = 0;
    while (!done_a && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(name, done_a, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " ctrl"}, {run_enable_a, dump_valid_a, done_a, dump_src_a, dump_addr_a,
                            reg_rd_addr_a, mem_rd_addr_a}, '0);
    check({name, " data/count"}, {dump_data_a, cycle_count_a}, '0);
  endtask

  initial begin
    int unsigned n;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + 32'(i * 7);
    for (int j = 0; j < 256; j++) mem[j] = 32'h3C00_0000 + 32'(j * 13);
    regs[8] = 32'hDEAD_BEEF;
    mem[3]  = 32'h1234_5678;
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; halt_b = 1'b0;
    dump_ready_a = 1'b1; dump_ready_b = 1'b1;

    #3;
    check_reset_outputs("reset state");
    check("B reset state", {run_enable_b, dump_valid_b, done_b, cycle_count_b}, '0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Full run to budget; start pulses in RUN and in REG_SEND are ignored
    push_full_a();
    run_cnt_a = 0; words_a = 0;
    pulse_start_a();
    repeat (3) @(posedge clock);
    #1 start_a = 1'b1;
    @(posedge clock);
    #1 start_a = 1'b0;
    n = 0;
    while (!(dump_valid_a && dump_src_a == 1'b0) && n < 100) begin
      @(posedge clock);
      #1 n++;
    end
    check("reached REG_SEND", {dump_valid_a, dump_src_a}, 2'b10);
    start_a = 1'b1;
    @(posedge clock);
    #1 start_a = 1'b0;
    wait_done_a("run1 done", 3000);
    check("run1 run_enable cycles", run_cnt_a, 16);
    check("run1 cycle_count", cycle_count_a, 16);
    check("run1 word count", words_a, 288);
    check("run1 queue drained", qa.size(), 0);

    // Restart from DONE with halt on run cycle 5
    push_full_a();
    run_cnt_a = 0; words_a = 0; halt_at = 5;
    pulse_start_a();
    check("restart done falls", done_a, 1'b0);
    check("restart cycle_count", cycle_count_a, 0);
    check("restart run_enable", run_enable_a, 1'b1);
    wait_done_a("run2 done", 3000);
    check("run2 run_enable cycles", run_cnt_a, 6);
    check("run2 cycle_count", cycle_count_a, 6);
    check("run2 word count", words_a, 288);
    halt_at = -1;

    // Back-pressure on r8 and mem[3]
    push_full_a();
    run_cnt_a = 0; words_a = 0; stall_en = 1'b1;
    pulse_start_a();
    wait_done_a("run3 done", 3000);
    check("run3 word count", words_a, 288);
    check("run3 r8 stall cycles", stall_r, 7);
    check("run3 mem3 stall cycles", stall_m, 7);
    stall_en = 1'b0;

    // Asynchronous reset while memory word 100 is presented
    push_full_a();
    run_cnt_a = 0; words_a = 0;
    pulse_start_a();
    n = 0;
    while (!(dump_valid_a && dump_src_a == 1'b1 && dump_addr_a == 8'd100) && n < 3000) begin
      @(posedge clock);
      #1 n++;
    end
    check("reached mem word 100", {dump_valid_a, dump_src_a, dump_addr_a}, {2'b11, 8'd100});
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    qa.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("idle after reset");
    push_full_a();
    run_cnt_a = 0; words_a = 0;
    pulse_start_a();
    wait_done_a("run4 done", 3000);
    check("run4 word count", words_a, 288);
    check("run4 cycle_count", cycle_count_a, 16);

    // Small instance: 4 registers + 5 memory words
    for (int i = 0; i < 4; i++) qb.push_back({1'b0, 8'(i), regs[i]});
    for (int j = 0; j < 5; j++) qb.push_back({1'b1, 8'(j), mem[j]});
    words_b = 0;
    @(posedge clock);
    #1 start_b = 1'b1;
    @(posedge clock);
    #1 start_b = 1'b0;
    n = 0;
    while (!done_b && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("B done", done_b, 1'b1);
    repeat (3) @(negedge clock);
    check("B word count", words_b, 9);
    check("B cycle_count", cycle_count_b, 3);
    check("B done holds", done_b, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
